alu_mc: RTL

Parametrised multi-cycle ALU for the MIPS datapath's execute stage. It adds a valid/ready handshake on both sides. Single-cycle logic and add operations complete in one cycle. Full-width multiply (low and high halves) and unsigned divide/remainder run on an iterative shift-add / shift-subtract engine that takes WIDTH cycles. The result and zero flag are registered and held until the consumer accepts them.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_iter_muldiv.sv | 117 +++++++++++
 rtl/alu_mc.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and sizing helpers for the multi-cycle execute-stage ALU.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALU_OPW   = 4;
    localparam int unsigned CNTW      = $clog2(ALU_WIDTH);

    typedef enum logic [ALU_OPW-1:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0100,
        OP_MUL  = 4'b0101,
        OP_SLT  = 4'b0110,
        OP_MULH = 4'b0111,
        OP_DIVU = 4'b1000,
        OP_REMU = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // Iteration counter width for a given operand width (WIDTH >= 2).
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring shift-subtract).
// The first step is folded into the start cycle, so WIDTH steps finish WIDTH-1 edges later.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;

    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;

    logic [W2-1:0]    src_acc;
    logic [WIDTH-1:0] src_quo;
    logic [WIDTH-1:0] src_b;
    logic             src_div;
    logic [WIDTH:0]   rem_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] new_hi;
    logic             ge;
    logic [W2-1:0]    step_acc;
    logic [WIDTH-1:0] step_quo;

    // One partial step, fed from the live operands on start, else from the registers.
    always_comb begin
        src_acc  = start ? {{WIDTH{1'b0}}, a} : acc_q;
        src_quo  = start ? '0 : quo_q;
        src_b    = start ? b : opb_q;
        src_div  = start ? is_div : div_q;

        rem_ext  = src_acc[W2-1:WIDTH-1];
        ge       = (rem_ext >= {1'b0, src_b});
        new_hi   = ge ? (rem_ext[WIDTH-1:0] - src_b) : rem_ext[WIDTH-1:0];
        sum      = {1'b0, src_acc[W2-1:WIDTH]} + {1'b0, src_b};

        step_acc = src_acc;
        step_quo = src_quo;
        if (src_div) begin
            step_acc = {new_hi, src_acc[WIDTH-2:0], 1'b0};
            step_quo = {src_quo[WIDTH-2:0], ge};
        end else if (src_acc[0]) begin
            step_acc = {sum, src_acc[WIDTH-1:1]};
        end else begin
            step_acc = {1'b0, src_acc[W2-1:1]};
        end
    end

    // Sequencing: load on start, step while the counter is non-zero, pulse done once.
    always_comb begin
        acc_d  = acc_q;
        quo_d  = quo_q;
        opb_d  = opb_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            acc_d = step_acc;
            quo_d = step_quo;
            opb_d = b;
            div_d = is_div;
            cnt_d = CW'(WIDTH - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                acc_d  = step_acc;
                quo_d  = step_quo;
                cnt_d  = cnt_q - CW'(1);
                done_d = (cnt_q == CW'(1));
            end else begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            quo_q  <= '0;
            opb_q  <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            quo_q  <= quo_d;
            opb_q  <= opb_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign hi   = acc_q[W2-1:WIDTH];
    assign lo   = div_q ? quo_q : acc_q[WIDTH-1:0];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready on both sides.
// Logic/add ops finish on the accept edge; MUL/MULH/DIVU/REMU run on the iterative engine.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [OPW-1:0]   alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag,
    output logic             busy
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             pick_hi_q, pick_hi_d;

    logic             accept;
    logic             start;
    logic             is_iter;
    logic             is_div_op;
    logic             want_hi;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH-1:0] iter_res;
    logic             eng_done;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    // Single-cycle datapath; unknown codes yield zero.
    always_comb begin
        single_res = '0;
        case (alu_op)
            OPW'(OP_AND): single_res = src_a & src_b;
            OPW'(OP_OR):  single_res = src_a | src_b;
            OPW'(OP_ADD): single_res = src_a + src_b;
            OPW'(OP_SUB): single_res = src_a - src_b;
            OPW'(OP_SLT): single_res = WIDTH'(src_a < src_b);
            default:      single_res = '0;
        endcase
    end

    always_comb begin
        is_div_op = (alu_op == OPW'(OP_DIVU)) || (alu_op == OPW'(OP_REMU));
        is_iter   = is_div_op || (alu_op == OPW'(OP_MUL)) || (alu_op == OPW'(OP_MULH));
        want_hi   = (alu_op == OPW'(OP_MULH)) || (alu_op == OPW'(OP_REMU));
    end

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign iter_res = pick_hi_q ? eng_hi : eng_lo;

    // Handshake FSM; a consumed result may be replaced by a new accept in the same cycle.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        pick_hi_d = pick_hi_q;
        start     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    if (is_iter) begin
                        state_d   = ST_BUSY;
                        start     = 1'b1;
                        pick_hi_d = want_hi;
                    end else begin
                        state_d  = ST_DONE;
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                    end
                end
            end
            ST_BUSY: begin
                if (eng_done) begin
                    state_d  = ST_DONE;
                    result_d = iter_res;
                    zero_d   = (iter_res == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            pick_hi_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            pick_hi_q <= pick_hi_d;
        end
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .is_div (is_div_op),
        .a      (src_a),
        .b      (src_b),
        .done   (eng_done),
        .hi     (eng_hi),
        .lo     (eng_lo)
    );

    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q == ST_BUSY);
    assign alu_result = result_q;
    assign zero_flag  = zero_q;

endmodule
